// File: rtl/ysyx_22050550_wbu.sv
// Writeback stage: captures one retiring instruction, waits for load data and commits to the regfile/bypass.
// Optional difftest commit ports are enabled by defining YSYX_22050550_DIFFTEST_EN.
module ysyx_22050550_wbu (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_LSU_valid,
    output logic        io_LSU_ready,
    input  logic [63:0] io_LSU_pc,
    input  logic [31:0] io_LSU_inst,
    input  logic        io_LSU_wen,
    input  logic [4:0]  io_LSU_waddr,
    input  logic [63:0] io_LSU_alures,
    input  logic        io_LSU_isload,
    input  logic [2:0]  io_LSU_ldtype,
    input  logic [2:0]  io_LSU_addrlo,
    input  logic        io_MEM_rvalid,
    input  logic [63:0] io_MEM_rdata,
    output logic        io_REG_wen,
    output logic [4:0]  io_REG_waddr,
    output logic [63:0] io_REG_wdata,
    output logic        io_WBU_valid,
    output logic [4:0]  io_WBU_waddr,
    output logic [63:0] io_WBU_rdata,
    output logic [63:0] io_commit_cnt
`ifdef YSYX_22050550_DIFFTEST_EN
    ,
    output logic        io_DIFF_valid,
    output logic [63:0] io_DIFF_pc,
    output logic [31:0] io_DIFF_inst
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_e;

    state_e      state_r, state_nxt_s;
    logic        ready_s, capture_s, enter_commit_s;
    logic        src_wen_s;
    logic [4:0]  src_waddr_s;
    logic [63:0] src_wdata_s, src_pc_s;
    logic [31:0] src_inst_s;

    logic        ins_wen_r;
    logic [4:0]  ins_waddr_r;
    logic [63:0] ins_pc_r;
    logic [31:0] ins_inst_r;
    logic [2:0]  ins_ldtype_r, ins_addrlo_r;

    logic        reg_wen_r;
    logic [4:0]  reg_waddr_r;
    logic [63:0] reg_wdata_r;
    logic [63:0] commit_cnt_r;
`ifdef YSYX_22050550_DIFFTEST_EN
    logic        diff_valid_r;
    logic [63:0] diff_pc_r;
    logic [31:0] diff_inst_r;
`endif

    // Byte-align the raw doubleword and extend it according to the load funct3; misalignment is not checked.
    function automatic logic [63:0] fmt_load(input logic [63:0] raw, input logic [2:0] ldtype,
                                             input logic [2:0] addrlo);
        logic [63:0] shifted;
        shifted = raw >> {addrlo, 3'b000};
        case (ldtype)
            3'b000:  fmt_load = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  fmt_load = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  fmt_load = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  fmt_load = {56'd0, shifted[7:0]};
            3'b101:  fmt_load = {48'd0, shifted[15:0]};
            3'b110:  fmt_load = {32'd0, shifted[31:0]};
            default: fmt_load = shifted;
        endcase
    endfunction

    // Next-state logic and selection of the instruction that enters COMMIT on the coming edge.
    always_comb begin
        ready_s        = (state_r == IDLE) || (state_r == COMMIT);
        capture_s      = io_LSU_valid && ready_s;
        state_nxt_s    = state_r;
        enter_commit_s = 1'b0;
        src_wen_s      = io_LSU_wen;
        src_waddr_s    = io_LSU_waddr;
        src_wdata_s    = io_LSU_alures;
        src_pc_s       = io_LSU_pc;
        src_inst_s     = io_LSU_inst;
        case (state_r)
            IDLE, COMMIT: begin
                if (capture_s) begin
                    if (io_LSU_isload) begin
                        state_nxt_s = WAIT_MEM;
                    end else begin
                        state_nxt_s    = COMMIT;
                        enter_commit_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_MEM: begin
                src_wen_s   = ins_wen_r;
                src_waddr_s = ins_waddr_r;
                src_wdata_s = fmt_load(io_MEM_rdata, ins_ldtype_r, ins_addrlo_r);
                src_pc_s    = ins_pc_r;
                src_inst_s  = ins_inst_r;
                if (io_MEM_rvalid) begin
                    state_nxt_s    = COMMIT;
                    enter_commit_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT_MEM;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, captured instruction and registered commit outputs; commit data holds outside COMMIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            ins_wen_r    <= 1'b0;
            ins_waddr_r  <= 5'd0;
            ins_pc_r     <= 64'd0;
            ins_inst_r   <= 32'd0;
            ins_ldtype_r <= 3'd0;
            ins_addrlo_r <= 3'd0;
            reg_wen_r    <= 1'b0;
            reg_waddr_r  <= 5'd0;
            reg_wdata_r  <= 64'd0;
            commit_cnt_r <= 64'd0;
`ifdef YSYX_22050550_DIFFTEST_EN
            diff_valid_r <= 1'b0;
            diff_pc_r    <= 64'd0;
            diff_inst_r  <= 32'd0;
`endif
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                ins_wen_r    <= io_LSU_wen;
                ins_waddr_r  <= io_LSU_waddr;
                ins_pc_r     <= io_LSU_pc;
                ins_inst_r   <= io_LSU_inst;
                ins_ldtype_r <= io_LSU_ldtype;
                ins_addrlo_r <= io_LSU_addrlo;
            end
            if (enter_commit_s) begin
                // x0 never writes and never forwards, but still retires.
                reg_wen_r    <= src_wen_s && (src_waddr_s != 5'd0);
                reg_waddr_r  <= src_waddr_s;
                reg_wdata_r  <= src_wdata_s;
                commit_cnt_r <= commit_cnt_r + 64'd1;
`ifdef YSYX_22050550_DIFFTEST_EN
                diff_valid_r <= 1'b1;
                diff_pc_r    <= src_pc_s;
                diff_inst_r  <= src_inst_s;
`endif
            end else begin
                reg_wen_r    <= 1'b0;
`ifdef YSYX_22050550_DIFFTEST_EN
                diff_valid_r <= 1'b0;
`endif
            end
        end
    end

    assign io_LSU_ready  = ready_s;
    assign io_REG_wen    = reg_wen_r;
    assign io_REG_waddr  = reg_waddr_r;
    assign io_REG_wdata  = reg_wdata_r;
    assign io_WBU_valid  = reg_wen_r;
    assign io_WBU_waddr  = reg_waddr_r;
    assign io_WBU_rdata  = reg_wdata_r;
    assign io_commit_cnt = commit_cnt_r;
`ifdef YSYX_22050550_DIFFTEST_EN
    assign io_DIFF_valid = diff_valid_r;
    assign io_DIFF_pc    = diff_pc_r;
    assign io_DIFF_inst  = diff_inst_r;
`else
    // Without difftest the captured pc/inst have no consumer.
    logic unused_s;
    assign unused_s = ^{src_pc_s, src_inst_s, ins_pc_r, ins_inst_r};
`endif

endmodule
